// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, flag layout,
// arbiter state encoding and op classification helpers.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  // Bit positions inside the 4-bit response flag vector {N, Z, V, C}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      ALU_PASS_B, ALU_ADD, ALU_SUBTRACT,
      ALU_AND, ALU_OR, ALU_XOR: legal = 1'b1;
      default:                  legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only add/subtract produce meaningful overflow and carry
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUBTRACT);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. On a tie the requester that did not win
// last time is chosen; last_grant resets to 1 so requester 0 wins first.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic       grant_valid,
  output logic       grant_id
);

  logic last_grant_reg;

  always_comb begin
    grant_valid = enable && (req != 2'b00);
    if (req == 2'b11) begin
      grant_id = ~last_grant_reg;
    end else begin
      grant_id = req[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (grant_valid) begin
      last_grant_reg <= grant_id;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// hold operands for SETTLE_CYCLES, then capture result/flags into a response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_cntrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_cntrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  arb_state_t       state_reg;
  arb_state_t       state_next;
  logic [3:0]       cnt_reg;
  logic             settle_done;
  logic             arb_enable;
  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_cntrl;
  logic [3:0]       flags_capture;

  // Reset also masks the grant so req_ready stays low while it is asserted
  assign arb_enable = (state_reg == IDLE) && !reset;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .enable      (arb_enable),
    .req         (req_valid),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_a       = grant_id ? req1_a     : req0_a;
  assign sel_b       = grant_id ? req1_b     : req0_b;
  assign sel_cntrl   = grant_id ? req1_cntrl : req0_cntrl;
  assign settle_done = (cnt_reg == SETTLE_LAST);
  assign resp_valid  = (state_reg == RESP);

  always_comb begin
    flags_capture         = '0;
    flags_capture[FLAG_N] = alu_negative;
    flags_capture[FLAG_Z] = alu_zero;
    flags_capture[FLAG_V] = is_arith_op(alu_cntrl) && alu_overflow;
    flags_capture[FLAG_C] = is_arith_op(alu_cntrl) && alu_carry_out;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          req_ready  = grant_id ? 2'b10 : 2'b01;
          state_next = is_legal_op(sel_cntrl) ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (settle_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cntrl   <= ALU_PASS_B;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_cntrl <= sel_cntrl;
            resp_id   <= grant_id;
            cnt_reg   <= '0;
            // Illegal ops bypass the ALU and answer with a zeroed error response
            if (!is_legal_op(sel_cntrl)) begin
              resp_err    <= 1'b1;
              resp_result <= '0;
              resp_flags  <= '0;
            end
          end
        end
        EXEC: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (settle_done) begin
            resp_result <= alu_result;
            resp_flags  <= flags_capture;
            resp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives the shared ALU
// port, and a round-robin/response reference model predicts every transaction.
module tb_alu_arbiter;

  localparam int W      = 64;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [W-1:0]  ra [2];
  logic [W-1:0]  rb [2];
  logic [2:0]    rop [2];
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]    alu_cntrl;
  logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic          resp_valid, resp_ready, resp_id, resp_err;
  logic [W-1:0]  resp_result;
  logic [3:0]    resp_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_last = 1;
  int last_grant_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req0_a        (ra[0]),
    .req0_b        (rb[0]),
    .req0_cntrl    (rop[0]),
    .req1_a        (ra[1]),
    .req1_b        (rb[1]),
    .req1_cntrl    (rop[1]),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_cntrl     (alu_cntrl),
    .alu_result    (alu_result),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_result   (resp_result),
    .resp_flags    (resp_flags),
    .resp_err      (resp_err)
  );

  // Shared ALU: its raw adder flags are live for every op, so the arbiter must mask them
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_result   = '0;
    alu_overflow = 1'b0;
    if (alu_cntrl == 3'b011) begin
      alu_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
      alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_sum[W-1] != alu_a[W-1]);
    end else begin
      alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
      alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_sum[W-1] != alu_a[W-1]);
    end
    case (alu_cntrl)
      3'b000:         alu_result = alu_b;
      3'b010, 3'b011: alu_result = alu_sum[W-1:0];
      3'b100:         alu_result = alu_a & alu_b;
      3'b101:         alu_result = alu_a | alu_b;
      3'b110:         alu_result = alu_a ^ alu_b;
      default:        alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    endcase
    alu_carry_out = alu_sum[W];
    alu_negative  = alu_result[W-1];
    alu_zero      = (alu_result == '0);
  end

  // Expected response {err, N, Z, V, C, result} from plain signed/unsigned arithmetic
  function automatic logic [68:0] ref_resp(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] op);
    logic signed [64:0] sx;
    logic [64:0]        ux;
    logic [63:0]        res;
    logic               v, c;
    v = 1'b0;
    c = 1'b0;
    res = '0;
    case (op)
      3'b000: res = b;
      3'b010: begin
        ux  = {1'b0, a} + {1'b0, b};
        sx  = $signed({a[63], a}) + $signed({b[63], b});
        res = ux[63:0];
        c   = ux[64];
        v   = (sx[64] != sx[63]);
      end
      3'b011: begin
        sx  = $signed({a[63], a}) - $signed({b[63], b});
        res = sx[63:0];
        c   = (a >= b);
        v   = (sx[64] != sx[63]);
      end
      3'b100: res = a & b;
      3'b101: res = a | b;
      3'b110: res = a ^ b;
      default: return {1'b1, 4'b0000, 64'd0};
    endcase
    return {1'b0, res[63], (res == 64'd0), v, c, res};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input int w, input logic [68:0] e);
    check({tag, "_id"},     64'(resp_id),    64'(w));
    check({tag, "_result"}, resp_result,     e[63:0]);
    check({tag, "_flags"},  64'(resp_flags), 64'(e[67:64]));
    check({tag, "_err"},    64'(resp_err),   64'(e[68]));
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic new_op(input int i, input bit legal_only);
    logic [2:0] legal_ops [6];
    legal_ops = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    ra[i] = pick_operand();
    rb[i] = pick_operand();
    if (legal_only) rop[i] = legal_ops[$urandom_range(0, 5)];
    else            rop[i] = 3'($urandom_range(0, 7));
    req_valid[i] = 1'b1;
  endtask

  // One complete transaction: grant, settle, response with optional back-pressure
  task automatic do_txn(input bit keep_valid, input int bp, input bit chk_interval);
    int          w;
    int          j;
    bit          got;
    logic [68:0] e;
    resp_ready = (bp == 0);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        got = 1;
        break;
      end
    end
    check("grant_seen", 64'(got), 64'd1);
    if (!got) return;
    if (req_valid == 2'b11) w = 1 - model_last;
    else                    w = req_valid[1] ? 1 : 0;
    check("grant_onehot", 64'(req_ready), (w == 1) ? 64'd2 : 64'd1);
    if (chk_interval) check("issue_interval", 64'(cyc - last_grant_cyc), 64'(SETTLE + 2));
    last_grant_cyc = cyc;
    model_last = w;
    e = ref_resp(ra[w], rb[w], rop[w]);
    @(posedge clk);
    #1;
    if (keep_valid) new_op(w, 1'b1);
    else            req_valid[w] = 1'b0;
    got = 0;
    for (j = 0; j < 40; j++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        break;
      end
      check("ready_low_exec", 64'(req_ready), 64'd0);
    end
    check("resp_seen", 64'(got), 64'd1);
    if (!got) return;
    check("latency", 64'(j), e[68] ? 64'd0 : 64'(SETTLE));
    check_resp("resp", w, e);
    $display("txn id=%0d op=%0d a=%h b=%h result=%h flags=%b err=%0d lat=%0d bp=%0d",
             w, rop[w], ra[w], rb[w], resp_result, resp_flags, resp_err, j, bp);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_no_grant", 64'(req_ready), 64'd0);
      check_resp("bp_hold", w, e);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("resp_cleared", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ra[i]  = '0;
      rb[i]  = '0;
      rop[i] = 3'b000;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",   64'(req_ready),   64'd0);
    check("rst_resp_valid",  64'(resp_valid),  64'd0);
    check("rst_resp_id",     64'(resp_id),     64'd0);
    check("rst_resp_result", resp_result,      64'd0);
    check("rst_resp_flags",  64'(resp_flags),  64'd0);
    check("rst_resp_err",    64'(resp_err),    64'd0);
    check("rst_alu_a",       alu_a,            64'd0);
    check("rst_alu_cntrl",   64'(alu_cntrl),   64'd0);
    reset = 1'b0;
    model_last = 1;

    // Single ADD, overflow/carry, and flag masking on a logical op
    ra[0] = 64'd1; rb[0] = 64'd1; rop[0] = 3'b010; req_valid = 2'b01;
    do_txn(1'b0, 0, 1'b0);
    ra[0] = 64'hFFFF_FFFF_FFFF_FFFF; rb[0] = 64'hFFFF_FFFF_FFFF_FFFF; rop[0] = 3'b100;
    req_valid = 2'b01;
    do_txn(1'b0, 0, 1'b0);
    check("alu_hold_a", alu_a, 64'hFFFF_FFFF_FFFF_FFFF);
    ra[1] = 64'h8000_0000_0000_0000; rb[1] = 64'h8000_0000_0000_0000; rop[1] = 3'b010;
    req_valid = 2'b10;
    do_txn(1'b0, 0, 1'b0);

    // Both requesters continuously valid: alternation at the full issue rate
    new_op(0, 1'b1);
    new_op(1, 1'b1);
    do_txn(1'b1, 0, 1'b0);
    for (int n = 0; n < 3; n++) do_txn(1'b1, 0, 1'b1);

    // Back-pressure with the other requester waiting, then illegal op codes
    do_txn(1'b0, 5, 1'b0);
    do_txn(1'b0, 0, 1'b0);
    ra[0] = 64'd5; rb[0] = 64'd9; rop[0] = 3'b111; req_valid = 2'b01;
    do_txn(1'b0, 0, 1'b0);
    ra[1] = 64'd5; rb[1] = 64'd9; rop[1] = 3'b001; req_valid = 2'b10;
    do_txn(1'b0, 2, 1'b0);

    // Randomised traffic, requests held until granted
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) new_op(i, 1'b0);
      if (req_valid == 2'b00) new_op(int'($urandom_range(0, 1)), 1'b0);
      do_txn(1'b0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
    end
    if (req_valid != 2'b00) begin
      for (int n = 0; n < 2 && req_valid != 2'b00; n++) do_txn(1'b0, 0, 1'b0);
    end

    // Reset during the first settle cycle of a SUB drops it without a response
    ra[1] = 64'd3; rb[1] = 64'd4; rop[1] = 3'b010;
    req_valid = 2'b10;
    resp_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) break;
    end
    check("pre_rst_grant", 64'(req_ready), 64'd2);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    ra[0] = 64'd100; rb[0] = 64'd7; rop[0] = 3'b011;
    req_valid = 2'b01;
    wait_resp_done: for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) break;
    end
    check("sub_grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_req_ready",  64'(req_ready),  64'd0);
    check("mid_rst_alu_a",      alu_a,           64'd0);
    @(negedge clk);
    check("mid_rst_req_ready_hold", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_last = 1;
    do_txn(1'b0, 0, 1'b0);
    do_txn(1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 64-bit ALU between two requesters.
- Each requester presents A, B and cntrl over a valid/ready handshake.
- The block grants round-robin, holds the operands stable on the ALU for a programmable settle time, then captures result and flags into a response register with valid/ready back-pressure.
- Sits between the register-read stage and the shared ALU instance.

Parameters:
- WIDTH, 64, operand/result width.
- SETTLE_CYCLES, 2, cycles ALU inputs are held before capture (ripple-carry settle); legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cntrl  in  3  requester 0 op code
- req1_a, req1_b  in  WIDTH  requester 1 operands
- req1_cntrl  in  3  requester 1 op code
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_cntrl  out  3  registered op code to ALU
- alu_result  in  WIDTH  ALU result
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accept
- resp_id  out  1  requester that issued the op
- resp_result  out  WIDTH  captured result
- resp_flags  out  4  {negative, zero, overflow, carry_out}
- resp_err  out  1  illegal op code

Behaviour:
- Op codes: 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR. 001 and 111 are illegal.
- Reset (sync, any state): state=IDLE; req_ready=0; alu_a/alu_b=0; alu_cntrl=000; resp_valid=0; resp_id=0; resp_result=0; resp_flags=0; resp_err=0; last_grant=1, so requester 0 wins first. Any in-flight op is dropped with no response.
- IDLE:
  - If any req_valid, grant one requester. If both are valid, grant the one not equal to last_grant.
  - req_ready[grant]=1 combinationally in this cycle only. The transfer occurs on that edge.
  - On the edge: latch operands into alu_a/alu_b/alu_cntrl, update last_grant, record resp_id.
  - Legal op: go to EXEC with cnt=0. Illegal op: skip EXEC and go to RESP with resp_err=1, resp_result=0, resp_flags=0.
- EXEC:
  - ALU inputs held constant; req_ready=0; cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, capture on that edge:
    - resp_result<=alu_result.
    - resp_flags<={alu_negative, alu_zero, ovf, co}. ovf/co pass through for ADD/SUB and are forced to 0 for PASS_B/AND/OR/XOR.
    - resp_err<=0; go to RESP.
- RESP:
  - resp_valid=1. All resp_* outputs are stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready: clear resp_valid and go to IDLE. No grant occurs in the same cycle.
- alu_* outputs keep their last value outside EXEC; they are not cleared after an op.
- Latency, legal op: grant edge to resp_valid high = SETTLE_CYCLES cycles. Issue interval with resp_ready tied high = SETTLE_CYCLES+2.
- Requests are never dropped. A requester keeps req_valid high until it sees its req_ready. Operand changes while unaccepted are permitted; the values sampled are those present on the grant edge.
- A req_valid that deasserts before its grant is a protocol violation. It is not checked.

Decomposition:
- Package alu_pkg:
  - cntrl localparams ALU_PASS_B, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR.
  - function is_legal_op.
  - function is_arith_op.
  - enum arb_state_t {IDLE, EXEC, RESP}.
  - flag bit-index constants.
- Sub-module rr_arb2: two-request round-robin grant logic with last_grant register, enable and reset inputs.
- The ALU itself is instantiated by the testbench/top, not inside this block.

Test Plan:
- Single request: req0 ADD A=1, B=1, resp_ready=1 -> resp_valid exactly SETTLE_CYCLES cycles after grant; resp_id=0, result=2, flags=0000, err=0.
- Overflow/carry: req1 ADD A=B=64'h8000000000000000 -> result=0, flags=0111 (N=0, Z=1, V=1, C=1), resp_id=1.
- Flag masking: req0 AND with A=B=64'hFFFFFFFFFFFFFFFF -> result=all ones, flags=1000 (N=1, Z=0, V and C forced 0).
- Round-robin: both valid continuously, 4 ops -> grant order 0,1,0,1. req_ready never has both bits high.
- Back-pressure and illegal op:
  - resp_ready=0 for 5 cycles -> resp_* held stable and no new grant occurs.
  - Cntrl=111 -> resp_err=1, result=0, resp_valid one cycle after grant, with no EXEC cycles.
- Reset mid-EXEC: assert reset at cnt=0 of a SUB -> next cycle resp_valid=0 and req_ready=0; after release, requester 0 is granted first.
